// File: rtl/conv2d_3x3_mul_arbiter_if.sv
// Request/response bundle between the conv2d_3x3 requesters and the shared multiplier.
// Handshake: a transfer happens on a rising edge where valid and ready are both high for the
// same index; valid never waits on ready, and valid plus payload stay stable until that edge.
interface conv2d_3x3_mul_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 14,
  parameter int B_WIDTH  = 12,
  parameter int P_WIDTH  = 26,
  parameter int ID_WIDTH = 2
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_REQ-1:0]         rsp_ready;
  logic [P_WIDTH-1:0]         rsp_data;
  logic [ID_WIDTH-1:0]        rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/conv2d_3x3_mul_arbiter.sv
// Round-robin arbiter sharing one A_WIDTH x B_WIDTH unsigned multiplier among NUM_REQ requesters.
// Two-stage pipeline (operands, then product); responses return in acceptance order.
module conv2d_3x3_mul_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 14,
  parameter int B_WIDTH  = 12,
  parameter int P_WIDTH  = 26,
  parameter int ID_WIDTH = 2
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  conv2d_3x3_mul_arbiter_if.slave bus
);

  logic                r_s1_vld;
  logic [ID_WIDTH-1:0] r_s1_id;
  logic [A_WIDTH-1:0]  r_s1_a;
  logic [B_WIDTH-1:0]  r_s1_b;
  logic                r_s2_vld;
  logic [ID_WIDTH-1:0] r_s2_id;
  logic [P_WIDTH-1:0]  r_s2_p;
  logic [ID_WIDTH-1:0] r_rr_ptr;

  logic                w_s2_free;
  logic                w_s1_adv;
  logic                w_s1_free;
  logic                w_found;
  logic [ID_WIDTH-1:0] w_gnt_id;
  logic [NUM_REQ-1:0]  w_gnt_vec;
  logic                w_take;
  logic [ID_WIDTH-1:0] w_ptr_nxt;
  logic [A_WIDTH-1:0]  w_sel_a;
  logic [B_WIDTH-1:0]  w_sel_b;
  logic [P_WIDTH-1:0]  w_prod;

  assign w_s2_free = !r_s2_vld || bus.rsp_ready[r_s2_id];
  assign w_s1_adv  = r_s1_vld && w_s2_free;
  assign w_s1_free = !r_s1_vld || w_s1_adv;

  // Wrapping search from r_rr_ptr; the first valid index found wins.
  always_comb begin : arb_search
    int idx;
    w_found   = 1'b0;
    w_gnt_id  = '0;
    w_gnt_vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && bus.req_valid[idx]) begin
        w_found        = 1'b1;
        w_gnt_id       = ID_WIDTH'(idx);
        w_gnt_vec[idx] = 1'b1;
      end
    end
  end

  // Reset gates the grant so req_ready drops together with the asynchronous reset.
  assign w_take        = w_found && w_s1_free && ap_rst_n;
  assign bus.req_ready = w_take ? w_gnt_vec : '0;

  assign w_ptr_nxt = (w_gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
  assign w_sel_a   = bus.req_a[w_gnt_id*A_WIDTH +: A_WIDTH];
  assign w_sel_b   = bus.req_b[w_gnt_id*B_WIDTH +: B_WIDTH];
  assign w_prod    = {{B_WIDTH{1'b0}}, r_s1_a} * {{A_WIDTH{1'b0}}, r_s1_b};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_id  <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_rr_ptr <= '0;
    end else if (w_take) begin
      r_s1_vld <= 1'b1;
      r_s1_id  <= w_gnt_id;
      r_s1_a   <= w_sel_a;
      r_s1_b   <= w_sel_b;
      r_rr_ptr <= w_ptr_nxt;
    end else if (w_s1_free) begin
      r_s1_vld <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s2_vld <= 1'b0;
      r_s2_id  <= '0;
      r_s2_p   <= '0;
    end else if (w_s1_adv) begin
      r_s2_vld <= 1'b1;
      r_s2_id  <= r_s1_id;
      r_s2_p   <= w_prod;
    end else if (w_s2_free) begin
      r_s2_vld <= 1'b0;
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (r_s2_vld) bus.rsp_valid[r_s2_id] = 1'b1;
  end

  assign bus.rsp_data = r_s2_p;
  assign bus.rsp_id   = r_s2_id;

endmodule

// File: tb/tb_conv2d_3x3_mul_arbiter.sv
// Bench for conv2d_3x3_mul_arbiter: directed scenarios plus random traffic, checked every
// cycle against an in-order queue model of a two-deep multiply pipeline with round-robin grant.
module tb_conv2d_3x3_mul_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int A_WIDTH  = 14;
  localparam int B_WIDTH  = 12;
  localparam int P_WIDTH  = 26;
  localparam int ID_WIDTH = 2;
  localparam logic [A_WIDTH-1:0] A_MAX = '1;
  localparam logic [B_WIDTH-1:0] B_MAX = '1;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;

  conv2d_3x3_mul_arbiter_if #(
    .NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH),
    .P_WIDTH(P_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) bus ();

  conv2d_3x3_mul_arbiter #(
    .NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH),
    .P_WIDTH(P_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus)
  );

  // clock / reset
  always #5 ap_clk = ~ap_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // scoreboard: expected responses {id, product} in acceptance order, with accept cycle
  logic [ID_WIDTH+P_WIDTH-1:0] exp_q[$];
  int                          acc_q[$];
  int                          m_cyc;
  int                          m_last_del;
  int                          m_ptr;
  int                          m_win;
  logic                        m_head_v;
  logic                        m_dlv;
  logic [ID_WIDTH+P_WIDTH-1:0] m_head;
  logic [ID_WIDTH-1:0]         m_hid;
  logic [NUM_REQ-1:0]          m_exp_rv;
  logic [NUM_REQ-1:0]          m_exp_rr;
  longint                      m_prod;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      exp_q.delete();
      acc_q.delete();
      m_cyc      = 0;
      m_last_del = -100;
      m_ptr      = 0;
    end else begin
      m_head_v = 1'b0;
      m_dlv    = 1'b0;
      m_exp_rv = '0;
      m_hid    = '0;
      m_head   = '0;
      if (exp_q.size() != 0) begin
        m_head = exp_q[0];
        // The head shows up two cycles after its accept and never before the cycle after
        // its predecessor left.
        if (acc_q[0] + 2 <= m_cyc && m_last_del + 1 <= m_cyc) begin
          m_head_v = 1'b1;
          m_hid    = m_head[P_WIDTH +: ID_WIDTH];
          m_exp_rv[m_hid] = 1'b1;
          m_dlv    = bus.rsp_ready[m_hid];
        end
      end
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_exp_rv));
      if (m_head_v) begin
        check("rsp_id", 32'(bus.rsp_id), 32'(m_hid));
        check("rsp_data", 32'(bus.rsp_data), 32'(m_head[P_WIDTH-1:0]));
      end
      // Two operations fit in flight; a third enters only when the oldest leaves this cycle.
      m_exp_rr = '0;
      m_win    = -1;
      if (exp_q.size() < 2 || m_dlv) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (m_win < 0 && bus.req_valid[(m_ptr + k) % NUM_REQ]) m_win = (m_ptr + k) % NUM_REQ;
        end
        if (m_win >= 0) m_exp_rr[m_win] = 1'b1;
      end
      check("req_ready", 32'(bus.req_ready), 32'(m_exp_rr));
      if (m_dlv) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        m_last_del = m_cyc;
      end
      if (m_win >= 0) begin
        m_prod = longint'(bus.req_a[m_win*A_WIDTH +: A_WIDTH]) *
                 longint'(bus.req_b[m_win*B_WIDTH +: B_WIDTH]);
        exp_q.push_back({ID_WIDTH'(m_win), m_prod[P_WIDTH-1:0]});
        acc_q.push_back(m_cyc);
        m_ptr = (m_win + 1) % NUM_REQ;
      end
      m_cyc++;
    end
  end

  // driver tasks
  logic [NUM_REQ-1:0] w_acc;
  logic [NUM_REQ-1:0] w_rsp_v;
  logic [P_WIDTH-1:0] w_rsp_d;
  logic [ID_WIDTH-1:0] w_rsp_id;

  task automatic set_req(input int i, input logic [A_WIDTH-1:0] a, input logic [B_WIDTH-1:0] b);
    bus.req_valid[i]                = 1'b1;
    bus.req_a[i*A_WIDTH +: A_WIDTH] = a;
    bus.req_b[i*B_WIDTH +: B_WIDTH] = b;
  endtask

  // One cycle: sample mid-cycle, then drop valid for requesters accepted at the edge.
  task automatic tick();
    @(negedge ap_clk);
    w_acc    = bus.req_valid & bus.req_ready;
    w_rsp_v  = bus.rsp_valid;
    w_rsp_d  = bus.rsp_data;
    w_rsp_id = bus.rsp_id;
    @(posedge ap_clk);
    #1;
    bus.req_valid = bus.req_valid & ~w_acc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.rsp_ready = '1;
    while ((exp_q.size() != 0 || bus.req_valid != '0) && n < 50) begin
      tick();
      n++;
    end
    check("drain_done", 32'(n < 50), 32'd1);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '1;
    repeat (3) @(posedge ap_clk);
    #1;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    ap_rst_n = 1'b1;

    // single request, two-cycle latency
    set_req(0, 3, 5);
    tick(); check("single_grant", 32'(w_acc), 32'b0001);
    tick(); check("single_c1_idle", 32'(w_rsp_v), 32'd0);
    tick(); check("single_rsp_v", 32'(w_rsp_v), 32'b0001);
    check("single_rsp_d", 32'(w_rsp_d), 32'd15);
    check("single_rsp_id", 32'(w_rsp_id), 32'd0);
    tick(); check("single_after", 32'(w_rsp_v), 32'd0);

    // maximum operands
    drain();
    set_req(2, A_MAX, B_MAX);
    tick(); tick(); tick();
    check("max_rsp_v", 32'(w_rsp_v), 32'b0100);
    check("max_rsp_d", 32'(w_rsp_d), 32'd67088385);
    check("max_rsp_id", 32'(w_rsp_id), 32'd2);

    // round-robin fairness from pointer 0
    drain();
    set_req(3, 1, 1);
    tick();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!bus.req_valid[i]) set_req(i, A_WIDTH'(100 + k*4 + i), B_WIDTH'(200 + i));
      tick();
      check("rr_order", 32'(w_acc), 32'(1 << (k % 4)));
    end

    // backpressure on requester 1
    drain();
    bus.rsp_ready = 4'b1101;
    set_req(1, 2, 7);
    tick(); check("bp_acc0", 32'(w_acc), 32'b0010);
    set_req(1, 4, 9);
    tick(); check("bp_acc1", 32'(w_acc), 32'b0010);
    set_req(2, 1, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_v", 32'(w_rsp_v), 32'b0010);
      check("bp_hold_d", 32'(w_rsp_d), 32'd14);
      check("bp_no_grant", 32'(w_acc), 32'd0);
    end
    bus.rsp_ready = '1;
    tick(); check("bp_rel_d0", 32'(w_rsp_d), 32'd14);
    check("bp_rel_grant", 32'(w_acc), 32'b0100);
    tick(); check("bp_rel_d1", 32'(w_rsp_d), 32'd36);
    check("bp_rel_v1", 32'(w_rsp_v), 32'b0010);

    // pointer skip: after grant to 0, req3 beats req0
    drain();
    set_req(0, 9, 9);
    tick(); check("skip_pre", 32'(w_acc), 32'b0001);
    set_req(3, 5, 5);
    set_req(0, 6, 6);
    tick(); check("skip_first", 32'(w_acc), 32'b1000);
    tick(); check("skip_second", 32'(w_acc), 32'b0001);

    // random traffic
    drain();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(1, 0) == 1)
          set_req(i,
                  ($urandom_range(7, 0) == 0) ? A_MAX : A_WIDTH'($urandom_range(16383, 0)),
                  ($urandom_range(7, 0) == 0) ? B_MAX : B_WIDTH'($urandom_range(4095, 0)));
        bus.rsp_ready[i] = ($urandom_range(3, 0) != 0);
      end
      tick();
    end

    // reset with both stages full; pointer sits at 3 beforehand
    drain();
    bus.rsp_ready = '0;
    set_req(1, 11, 13);
    tick(); check("rst_fill1", 32'(w_acc), 32'b0010);
    set_req(2, 17, 19);
    tick(); check("rst_fill2", 32'(w_acc), 32'b0100);
    set_req(0, 5, 6);
    set_req(3, 7, 8);
    tick(); check("rst_full_stall", 32'(w_acc), 32'd0);
    check("rst_full_rsp", 32'(w_rsp_v), 32'b0010);
    ap_rst_n = 1'b0;
    #1;
    check("rst_async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_async_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    tick();
    ap_rst_n      = 1'b1;
    bus.rsp_ready = '1;
    tick(); check("post_rst_grant", 32'(w_acc), 32'b0001);
    check("post_rst_no_stale", 32'(w_rsp_v), 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
